// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: round-robin sequencer/arbiter sharing the two ports of a
// 1-bit-wide synchronous RAM (registered read, 1-cycle latency) among NUM_REQ
// requesters. Up to two grants per cycle; read data is routed back per lane.
// Optional post-reset RAM clear: define DUAL_PORT_RAM_CTRL_INIT_EN.

// Per-requester response lane: tracks which RAM port carries its read.
module dpr_resp_lane (
  input  logic clk,
  input  logic rst,
  input  logic rd_grant,
  input  logic rd_port,     // 0 = port 1, 1 = port 2
  input  logic out1,
  input  logic out2,
  output logic resp_valid,
  output logic resp_data
);
  logic pend;
  logic sel;

  // Capture the grant so the response lines up with the RAM's registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      sel  <= 1'b0;
    end else begin
      pend <= rd_grant;
      sel  <= rd_port;
    end
  end

  // rst masks the pulse so a reset right after a grant drops the response
  always_comb begin
    resp_valid = pend & ~rst;
    resp_data  = resp_valid & (sel ? out2 : out1);
  end
endmodule

module dual_port_ram_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ-1:0]            resp_data,
  output logic                          init_done,
  output logic [ADDR_WIDTH-1:0]         addr1,
  output logic [ADDR_WIDTH-1:0]         addr2,
  output logic                          we1,
  output logic                          we2,
  output logic                          data1,
  output logic                          data2,
  input  logic                          out1,
  input  logic                          out2
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [PW-1:0]         rr_ptr, rr_nxt;
  logic [PW-1:0]         a_idx, b_idx, idx;
  logic [SW-1:0]         sum;
  logic                  a_vld, b_vld, done;
  logic                  active, gnt_a, gnt_b;
  logic [NUM_REQ-1:0]    rd_grant, rd_port;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    if (v == PW'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_grant[gi] = req_ready[gi] & ~req_we[gi];
      assign rd_port[gi]  = gnt_b && (b_idx == PW'(gi));
      dpr_resp_lane u_lane (
        .clk        (clk),
        .rst        (rst),
        .rd_grant   (rd_grant[gi]),
        .rd_port    (rd_port[gi]),
        .out1       (out1),
        .out2       (out2),
        .resp_valid (resp_valid[gi]),
        .resp_data  (resp_data[gi])
      );
    end
  endgenerate

  // Traffic is only accepted once the controller is up and not in reset
  assign active = init_done & ~rst;

  // Round-robin scan from rr_ptr: first valid gets port 1, next gets port 2
  // unless it collides on address with a write; a collision ends the scan.
  always_comb begin
    a_vld = 1'b0;
    b_vld = 1'b0;
    done  = 1'b0;
    a_idx = '0;
    b_idx = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = SW'(rr_ptr) + SW'(k);
      idx = PW'((sum >= SW'(NUM_REQ)) ? sum - SW'(NUM_REQ) : sum);
      if (req_valid[idx] && !done) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else begin
          done = 1'b1;
          if (!((req_we[a_idx] | req_we[idx]) && (addr_arr[a_idx] == addr_arr[idx]))) begin
            b_vld = 1'b1;
            b_idx = idx;
          end
        end
      end
    end
  end

  assign gnt_a = a_vld & active;
  assign gnt_b = b_vld & active;

  // Ready mirrors the grant; pointer advances past the last granted requester
  always_comb begin
    req_ready = '0;
    rr_nxt    = rr_ptr;
    if (gnt_a) begin
      req_ready[a_idx] = 1'b1;
      rr_nxt           = inc_mod(a_idx);
    end
    if (gnt_b) begin
      req_ready[b_idx] = 1'b1;
      rr_nxt           = inc_mod(b_idx);
    end
  end

`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t                state;
  logic [ADDR_WIDTH-2:0] cnt;
  logic                  init_phase;

  assign init_phase = (state == INIT) & ~rst;

  // Sequencer: clear the RAM two words per cycle, then arbitrate
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          rr_ptr    <= rr_nxt;
        end
        default: state <= INIT;
      endcase
    end
  end
`else
  // No clear pass: ready the cycle after reset, then arbitrate
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      init_done <= 1'b1;
      rr_ptr    <= rr_nxt;
    end
  end
`endif

  // RAM port drive: clear pattern during INIT, else the granted requests
  always_comb begin
    addr1 = '0;
    addr2 = '0;
    we1   = 1'b0;
    we2   = 1'b0;
    data1 = 1'b0;
    data2 = 1'b0;
`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
    if (init_phase) begin
      addr1 = {cnt, 1'b0};
      addr2 = {cnt, 1'b1};
      we1   = 1'b1;
      we2   = 1'b1;
    end
`endif
    if (gnt_a) begin
      addr1 = addr_arr[a_idx];
      we1   = req_we[a_idx];
      data1 = req_we[a_idx] & req_data[a_idx];
    end
    if (gnt_b) begin
      addr2 = addr_arr[b_idx];
      we2   = req_we[b_idx];
      data2 = req_we[b_idx] & req_data[b_idx];
    end
  end
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Directed bench for dual_port_ram_ctrl with a behavioural two-port RAM.
// Covers both builds of DUAL_PORT_RAM_CTRL_INIT_EN.
module tb_dual_port_ram_ctrl;
  localparam int AW = 9;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid, req_we, req_data;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready, resp_valid, resp_data;
  logic              init_done, we1, we2, data1, data2, out1, out2;
  logic [AW-1:0]     addr1, addr2;
  logic              mem [0:(1<<AW)-1];
  bit                mem_ready = 1'b0;
  int                nchk = 0;
  int                nerr = 0;

`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
  localparam logic MEM_INIT = 1'b1;  // clear pass must overwrite this
`else
  localparam logic MEM_INIT = 1'b0;
`endif

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .init_done(init_done),
    .addr1(addr1), .addr2(addr2), .we1(we1), .we2(we2),
    .data1(data1), .data2(data2), .out1(out1), .out2(out2)
  );

  // Two-port RAM with registered read
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int j = 0; j < (1<<AW); j++) mem[j] <= MEM_INIT;
      mem_ready <= 1'b1;
    end else begin
      if (we1) mem[addr1] <= data1;
      if (we2) mem[addr2] <= data2;
    end
    out1 <= mem[addr1];
    out2 <= mem[addr2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic d);
    req_valid[i] = v;
    req_we[i]    = w;
    req_addr[i*AW +: AW] = a;
    req_data[i]  = d;
  endtask

`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
  // Called in the first cycle with rst low; returns in the first RUN cycle
  task automatic init_check(input string tag);
    int seen [1<<AW];
    int early = 0, wbad = 0, rdy = 0, cov = 0;
    for (int j = 0; j < (1<<AW); j++) seen[j] = 0;
    req_valid = '1;
    req_we    = '0;
    for (int i = 0; i < (1<<(AW-1)); i++) begin
      #1;
      if (init_done !== 1'b0) early++;
      if (!(we1 === 1'b1 && we2 === 1'b1 && data1 === 1'b0 && data2 === 1'b0)) wbad++;
      if (req_ready !== '0) rdy++;
      seen[addr1]++;
      seen[addr2]++;
      if (i == (1<<(AW-1)) - 1) req_valid = '0;
      nxt();
    end
    for (int j = 0; j < (1<<AW); j++) if (seen[j] != 1) cov++;
    chk({tag, "_done_early"}, early, 0);
    chk({tag, "_we_data"}, wbad, 0);
    chk({tag, "_ready"}, rdy, 0);
    chk({tag, "_addr_cover"}, cov, 0);
    chk({tag, "_done_at_256"}, init_done, 1);
  endtask

  // Read every address two at a time; all must come back 0
  task automatic sweep_check();
    int bad = 0, rbad = 0;
    for (int k = 0; k <= (1<<(AW-1)); k++) begin
      req_valid = '0;
      if (k < (1<<(AW-1))) begin
        set_req(0, 1'b1, 1'b0, AW'(2*k), 1'b0);
        set_req(1, 1'b1, 1'b0, AW'(2*k+1), 1'b0);
      end
      #1;
      if (k < (1<<(AW-1)) && req_ready !== 4'b0011) rbad++;
      if (k > 0 && (resp_valid !== 4'b0011 || resp_data !== 4'b0000)) bad++;
      nxt();
    end
    req_valid = '0;
    chk("sweep_ready", rbad, 0);
    chk("sweep_zero", bad, 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_we = '0; req_data = '0; req_addr = '0;
    rst = 1'b1;
    nxt(); nxt();
    // Reset state, with requests presented
    req_valid = '1; req_we = '1; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_we", {we1, we2}, 0);
    chk("rst_addr", {addr1, addr2}, 0);
    req_valid = '0; req_we = '0;
    nxt(); rst = 1'b0;
`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
    init_check("init1");
`else
    #1 chk("init_done_c0", init_done, 0);
    nxt();
    chk("init_done_c1", init_done, 1);
`endif

    // Write 1 to 0x05, then read it back (rr_ptr=0)
    set_req(0, 1'b1, 1'b1, 9'h05, 1'b1); #1;
    chk("wr_ready", req_ready, 4'b0001);
    chk("wr_port1", {we1, addr1, data1}, {1'b1, 9'h05, 1'b1});
    chk("wr_port2_idle", {we2, addr2}, 0);
    nxt(); set_req(0, 1'b1, 1'b0, 9'h05, 1'b0); #1;
    chk("wr_no_resp", resp_valid, 0);
    chk("rd_ready", req_ready, 4'b0001);
    nxt(); req_valid = '0; set_req(3, 1'b1, 1'b0, 9'h020, 1'b0); #1;
    chk("rd_resp_valid", resp_valid, 4'b0001);
    chk("rd_resp_data", resp_data[0], 1);
    chk("steer0_ready", req_ready, 4'b1000);

    // Four-way contention from rr_ptr=0
    nxt();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(9'h40 + i), 1'b0);
    #1;
    chk("pulse_end", resp_valid, 4'b1000);
    chk("rr4_addr", {addr1, addr2}, {9'h40, 9'h41});
    for (int c = 0; c < 4; c++) begin
      chk("rr4_ready", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      if (c > 0) chk("rr4_resp", resp_valid, (c % 2 == 1) ? 4'b0011 : 4'b1100);
      nxt();
    end
    req_valid = '0; set_req(0, 1'b1, 1'b0, 9'h05, 1'b0); #1;
    chk("rr4_resp_last", resp_valid, 4'b1100);
    chk("steer1_ready", req_ready, 4'b0001);

    // Same-address writes from 1 and 2 (rr_ptr=1); 3 must not be scanned
    nxt();
    req_valid = '0;
    set_req(1, 1'b1, 1'b1, 9'h10, 1'b0);
    set_req(2, 1'b1, 1'b1, 9'h10, 1'b1);
    set_req(3, 1'b1, 1'b0, 9'h30, 1'b0);
    #1;
    chk("rd05_resp", {resp_valid, resp_data[0]}, {4'b0001, 1'b1});
    chk("cf_t_ready", req_ready, 4'b0010);
    chk("cf_t_port2_idle", we2, 0);
    nxt(); req_valid[1] = 1'b0; #1;
    chk("cf_t1_ready", req_ready, 4'b1100);
    chk("cf_t1_port1", {we1, addr1, data1}, {1'b1, 9'h10, 1'b1});
    nxt();
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 9'h10, 1'b0);
    set_req(3, 1'b1, 1'b0, 9'h10, 1'b0);
    #1;
    chk("cf_rd3_resp", resp_valid, 4'b1000);
    chk("same_rd_ready", req_ready, 4'b1001);
    chk("same_rd_addr", {addr1, addr2}, {9'h10, 9'h10});
    nxt(); req_valid = '0; set_req(0, 1'b1, 1'b0, 9'h05, 1'b0); #1;
    chk("same_rd_resp", resp_valid, 4'b1001);
    chk("cf_final_data", {resp_data[3], resp_data[0]}, 2'b11);
    chk("rst_pre_grant", req_ready, 4'b0001);

    // Reset one cycle after a read grant
    nxt(); rst = 1'b1; req_valid = '1; #1;
    chk("rst_drop_resp", resp_valid, 0);
    chk("rst_ready_mid", req_ready, 0);
    nxt();
    chk("rst_init_done_mid", init_done, 0);
    chk("rst_resp_mid", resp_valid, 0);
    chk("rst_ready_mid2", req_ready, 0);
    rst = 1'b0; req_valid = '0; #1;
    chk("rst_after_resp", resp_valid, 0);
    chk("rst_after_init_done", init_done, 0);
`ifdef DUAL_PORT_RAM_CTRL_INIT_EN
    chk("init_restart", {we1, we2, addr1, addr2}, {2'b11, 9'h000, 9'h001});
    init_check("init2");
    sweep_check();
`else
    nxt();
    chk("init_done_c1_again", init_done, 1);
`endif

    // Back-to-back write/read at the top address
    set_req(0, 1'b1, 1'b1, 9'h1FF, 1'b1); #1;
    chk("top_wr_ready", req_ready, 4'b0001);
    chk("top_wr_port", {we1, addr1, data1}, {1'b1, 9'h1FF, 1'b1});
    nxt(); set_req(0, 1'b1, 1'b0, 9'h1FF, 1'b0); #1;
    chk("top_rd_ready", req_ready, 4'b0001);
    nxt(); req_valid = '0; #1;
    chk("top_resp", {resp_valid, resp_data[0]}, {4'b0001, 1'b1});
    nxt();
    chk("top_pulse_end", resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
